// File: rtl/store.sv
// Store unit: turns byte/halfword/word store requests from the execute stage
// into a single big-endian-laned Wishbone write cycle and reports the outcome
// (done or error) to the core with a one-cycle pulse.
module store #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_store,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [31:0] o_wb_addr,
  output logic        o_wb_cyc,
  output logic [3:0]  o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  localparam logic        S_IDLE = 1'b0;
  localparam logic        S_BUS  = 1'b1;
  localparam logic        TO_EN  = (TIMEOUT != 0);
  localparam logic [TW:0] TO_LIM = (TW+1)'(TIMEOUT);

  logic          state;
  logic          state_nxt;
  logic [TW-1:0] tcount;
  logic [TW-1:0] tcount_nxt;
  logic          aligned;
  logic [3:0]    stb_sel;
  logic [31:0]   dat_sel;
  logic          timeout_hit;
  logic          busy_nxt;
  logic          done_nxt;
  logic          error_nxt;
  logic          cyc_nxt;
  logic [3:0]    stb_nxt;
  logic [31:0]   addr_nxt;
  logic [31:0]   dat_nxt;

  // The bus only ever writes.
  assign o_wb_we = 1'b1;

  // Decode request size into alignment check, lane strobes and replicated data.
  always_comb begin
    aligned = 1'b0;
    stb_sel = 4'b0000;
    dat_sel = 32'h0000_0000;
    case (i_store)
      2'b01: begin
        aligned = 1'b1;
        dat_sel = {4{i_data[7:0]}};
        case (i_addr[1:0])
          2'b00:   stb_sel = 4'b1000;
          2'b01:   stb_sel = 4'b0100;
          2'b10:   stb_sel = 4'b0010;
          default: stb_sel = 4'b0001;
        endcase
      end
      2'b10: begin
        aligned = ~i_addr[0];
        dat_sel = {2{i_data[15:0]}};
        if (i_addr[1]) stb_sel = 4'b0011;
        else           stb_sel = 4'b1100;
      end
      2'b11: begin
        aligned = (i_addr[1:0] == 2'b00);
        dat_sel = i_data;
        stb_sel = 4'b1111;
      end
      default: begin
        aligned = 1'b0;
        stb_sel = 4'b0000;
        dat_sel = 32'h0000_0000;
      end
    endcase
  end

  // Timeout fires in the BUS cycle whose increment would reach TIMEOUT.
  always_comb begin
    if (TO_EN) timeout_hit = (({1'b0, tcount} + {{TW{1'b0}}, 1'b1}) == TO_LIM);
    else       timeout_hit = 1'b0;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: enter BUS on an aligned request, leave on ack/err/timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if ((i_store != 2'b00) && aligned) state_nxt = S_BUS;
        else                               state_nxt = S_IDLE;
      end
      S_BUS: begin
        if (i_wb_err || i_wb_ack || timeout_hit) state_nxt = S_IDLE;
        else                                     state_nxt = S_BUS;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus and status outputs.
  always_comb begin
    busy_nxt   = (state_nxt == S_BUS);
    done_nxt   = 1'b0;
    error_nxt  = 1'b0;
    cyc_nxt    = o_wb_cyc;
    stb_nxt    = o_wb_stb;
    addr_nxt   = o_wb_addr;
    dat_nxt    = o_wb_dat;
    tcount_nxt = tcount;
    case (state)
      S_IDLE: begin
        if (i_store != 2'b00) begin
          if (aligned) begin
            cyc_nxt    = 1'b1;
            stb_nxt    = stb_sel;
            addr_nxt   = {i_addr[31:2], 2'b00};
            dat_nxt    = dat_sel;
            tcount_nxt = {TW{1'b0}};
          end else begin
            error_nxt = 1'b1;
          end
        end else begin
          cyc_nxt = 1'b0;
        end
      end
      S_BUS: begin
        // err beats ack; ack beats a simultaneous timeout
        if (i_wb_err) begin
          cyc_nxt   = 1'b0;
          stb_nxt   = 4'b0000;
          error_nxt = 1'b1;
        end else if (i_wb_ack) begin
          cyc_nxt  = 1'b0;
          stb_nxt  = 4'b0000;
          done_nxt = 1'b1;
        end else if (timeout_hit) begin
          cyc_nxt    = 1'b0;
          stb_nxt    = 4'b0000;
          error_nxt  = 1'b1;
          tcount_nxt = tcount + {{(TW-1){1'b0}}, 1'b1};
        end else begin
          tcount_nxt = tcount + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        cyc_nxt = 1'b0;
        stb_nxt = 4'b0000;
      end
    endcase
  end

  // Output and timeout counter registers; reset drops the bus with no pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 4'b0000;
      o_wb_addr <= 32'h0000_0000;
      o_wb_dat  <= 32'h0000_0000;
      tcount    <= {TW{1'b0}};
    end else begin
      o_busy    <= busy_nxt;
      o_done    <= done_nxt;
      o_error   <= error_nxt;
      o_wb_cyc  <= cyc_nxt;
      o_wb_stb  <= stb_nxt;
      o_wb_addr <= addr_nxt;
      o_wb_dat  <= dat_nxt;
      tcount    <= tcount_nxt;
    end
  end

endmodule
